// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Instruction store plus fetch stage. A loader streams words into the store
// one per clock while LoadInstructions is high. Once loading stops and Reset
// has been pulsed, the block fetches the words in order into the IF/ID
// register. It supports decode stalls, branch redirect with flush, NOP fill
// past the end of the program, sticky overflow detection and a sticky
// program-done flag.
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   Reset            in   synchronous active-high, clears fetch state only
//   ClearProgram     in   synchronous, empties the program (count + overflow)
//   LoadInstructions in   1 = load mode (fetch frozen), 0 = run mode
//   Instruction      in   word written in load mode
//   Stall            in   hold PC and IF/ID
//   BranchTaken      in   redirect fetch to BranchTarget and flush IF/ID
//   BranchTarget     in   byte address of the redirect, bits [1:0] ignored
//   IF_ID_Instr      out  fetched instruction
//   IF_ID_PC         out  byte address of IF_ID_Instr
//   IF_ID_Valid      out  IF_ID_Instr is a real loaded instruction
//   LoadCount        out  number of words in the current program
//   LoadOverflow     out  sticky, a load word was dropped (store full)
//   Done             out  sticky, fetch PC has reached LoadCount
//
// Load-session tracking FSM
//   state  | meaning
//   S_RUN  | previous cycle was not a load cycle; next load starts a session
//   S_LOAD | a load session is in progress; next load appends
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int                WIDTH = 32,
    parameter int                DEPTH = 64,
    parameter int                AW    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  NOP   = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              ClearProgram,
    input  logic              LoadInstructions,
    input  logic [WIDTH-1:0]  Instruction,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    output logic [WIDTH-1:0]  IF_ID_Instr,
    output logic [31:0]       IF_ID_PC,
    output logic              IF_ID_Valid,
    output logic [AW:0]       LoadCount,
    output logic              LoadOverflow,
    output logic              Done
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              load_en;
    logic              session_start;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    logic [AW:0]       pc;
    logic [AW:0]       pc_inc;
    logic              pc_in_prog;
    logic [WIDTH-1:0]  fetch_word;

    logic [AW-1:0]     tgt_slot;
    logic [AW:0]       tgt_ext;
    logic [AW:0]       tgt_pc;

    logic              unused_tgt_bits;

    // ------------------------------------------------------------------
    // Session tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_en       = 1'b0;
        session_start = 1'b0;
        if (Reset) begin
            state_d = S_RUN;
        end else if (LoadInstructions) begin
            state_d       = S_LOAD;
            load_en       = 1'b1;
            session_start = (state_q == S_RUN);
        end else begin
            state_d = S_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Program count and overflow. ClearProgram beats an in-flight load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ClearProgram) begin
            LoadCount    <= '0;
            LoadOverflow <= 1'b0;
        end else if (load_en) begin
            if (session_start) begin
                LoadCount <= ONE_V;
            end else if (LoadCount == DEPTH_V) begin
                LoadOverflow <= 1'b1;
            end else begin
                LoadCount <= LoadCount + ONE_V;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store: synchronous write, combinational read, no reset
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = load_en && !ClearProgram &&
                    (session_start || (LoadCount != DEPTH_V));
        mem_waddr = session_start ? '0 : LoadCount[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= Instruction;
        end
    end

    // ------------------------------------------------------------------
    // Fetch datapath
    // ------------------------------------------------------------------
    // The slot lookup is only used when pc < LoadCount <= DEPTH, so the
    // truncated index is always in range when it matters.
    always_comb begin
        pc_in_prog = (pc < LoadCount);
        fetch_word = pc_in_prog ? mem[pc[AW-1:0]] : NOP;
        pc_inc     = (pc == DEPTH_V) ? pc : pc + ONE_V;
    end

    // The redirect keeps only the slot-index bits; for a non-power-of-two
    // store one subtraction folds the index back into range.
    always_comb begin
        tgt_slot = BranchTarget[AW+1:2];
        tgt_ext  = {1'b0, tgt_slot};
        tgt_pc   = (tgt_ext >= DEPTH_V) ? (tgt_ext - DEPTH_V) : tgt_ext;
    end

    assign unused_tgt_bits = ^{BranchTarget[31:AW+2], BranchTarget[1:0]};

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc          <= '0;
            IF_ID_Instr <= NOP;
            IF_ID_PC    <= '0;
            IF_ID_Valid <= 1'b0;
            Done        <= 1'b0;
        end else if (LoadInstructions) begin
            IF_ID_Instr <= NOP;
            IF_ID_Valid <= 1'b0;
        end else begin
            if (!pc_in_prog) begin
                Done <= 1'b1;
            end
            if (BranchTaken) begin
                pc          <= tgt_pc;
                IF_ID_Instr <= NOP;
                IF_ID_PC    <= '0;
                IF_ID_Valid <= 1'b0;
            end else if (!Stall) begin
                pc          <= pc_inc;
                IF_ID_Instr <= fetch_word;
                IF_ID_PC    <= 32'({pc, 2'b00});
                IF_ID_Valid <= pc_in_prog;
            end
        end
    end

endmodule
